// File: rtl/color_centroid_tracker_pkg.sv
// Shared constants, FSM state encoding and saturating accumulator helpers
// for the colour centroid tracker.
package color_centroid_tracker_pkg;

    localparam int CNT_W        = 19;
    localparam int SUM_W        = 28;
    localparam int COORD_W      = 10;
    localparam int FRAME_W      = 640;
    localparam int FRAME_H      = 480;
    localparam int FRAME_PIXELS = FRAME_W * FRAME_H;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHECK  = 3'd1,
        ST_DIV_X  = 3'd2,
        ST_DIV_Y  = 3'd3,
        ST_UPDATE = 3'd4
    } state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [SUM_W-1:0] sat_add(input logic [SUM_W-1:0] s,
                                                 input logic [COORD_W-1:0] c);
        logic [SUM_W:0] t;
        t = {1'b0, s} + {{(SUM_W + 1 - COORD_W){1'b0}}, c};
        return t[SUM_W] ? {SUM_W{1'b1}} : t[SUM_W-1:0];
    endfunction

endpackage

// File: rtl/color_centroid_tracker_seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle. The first bit is
// resolved in the start cycle, so done pulses exactly SUM_W cycles after start.
module seq_divider
    import color_centroid_tracker_pkg::*;
(
    input  logic             iCLK,
    input  logic             iRST_N,
    input  logic             start,
    input  logic [SUM_W-1:0] dividend,
    input  logic [CNT_W-1:0] divisor,
    output logic [SUM_W-1:0] quotient,
    output logic             busy,
    output logic             done
);

    localparam int STEP_W = $clog2(SUM_W);

    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [SUM_W-1:0]  quo_q, quo_d;
    logic [CNT_W-1:0]  div_q, div_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic             load;
    logic [CNT_W-1:0] src_rem;
    logic [CNT_W-1:0] src_div;
    logic [SUM_W-1:0] src_quo;
    logic [CNT_W:0]   rem_sh;
    logic [CNT_W-1:0] diff;
    logic             fits;

    assign load = start && !busy_q;

    always_comb begin
        src_rem = load ? '0 : rem_q;
        src_quo = load ? dividend : quo_q;
        src_div = load ? divisor : div_q;
        rem_sh  = {src_rem, src_quo[SUM_W-1]};
        fits    = (rem_sh >= {1'b0, src_div});
        // remainder after subtraction is below the divisor, so CNT_W bits suffice
        diff    = rem_sh[CNT_W-1:0] - src_div;
    end

    always_comb begin
        rem_d  = rem_q;
        quo_d  = quo_q;
        div_d  = div_q;
        step_d = step_q;
        busy_d = busy_q;
        done_d = 1'b0;
        if (load || busy_q) begin
            rem_d = fits ? diff : rem_sh[CNT_W-1:0];
            quo_d = {src_quo[SUM_W-2:0], fits};
        end
        if (load) begin
            div_d  = divisor;
            step_d = STEP_W'(SUM_W - 1);
            busy_d = 1'b1;
        end else if (busy_q) begin
            step_d = step_q - STEP_W'(1);
            if (step_q == STEP_W'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            rem_q  <= '0;
            quo_q  <= '0;
            div_q  <= '0;
            step_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            div_q  <= div_d;
            step_q <= step_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign quotient = quo_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: rtl/color_centroid_tracker.sv
// Per-frame green centroid and red click tracker on the VGA pixel clock.
//
// state     | meaning
// ST_IDLE   | accumulating, waiting for VS falling edge
// ST_CHECK  | snapshot taken, decide found / launch X division
// ST_DIV_X  | dividing sum_x by green count
// ST_DIV_Y  | dividing sum_y by green count
// ST_UPDATE | commit centroid, found flag, click hysteresis; pulse oVALID
module color_centroid_tracker
    import color_centroid_tracker_pkg::*;
#(
    parameter int MIN_PIXELS = 64,
    parameter int CLICK_ON   = 1500,
    parameter int CLICK_OFF  = 1000
) (
    input  logic               iCLK,
    input  logic               iRST_N,
    input  logic               iVALID,
    input  logic [COORD_W-1:0] iX,
    input  logic [COORD_W-1:0] iY,
    input  logic               iVS,
    input  logic               iGREEN_HIT,
    input  logic               iRED_HIT,
    output logic [COORD_W-1:0] oX,
    output logic [COORD_W-1:0] oY,
    output logic               oFOUND,
    output logic               oCLICK,
    output logic               oVALID,
    output logic               oOVERRUN
);

    localparam logic [CNT_W-1:0] MIN_PIX_C   = CNT_W'(MIN_PIXELS);
    localparam logic [CNT_W-1:0] CLICK_ON_C  = CNT_W'(CLICK_ON);
    localparam logic [CNT_W-1:0] CLICK_OFF_C = CNT_W'(CLICK_OFF);

    logic               vs_q;
    logic [CNT_W-1:0]   g_cnt_q, g_cnt_d, r_cnt_q, r_cnt_d;
    logic [SUM_W-1:0]   g_sx_q, g_sx_d, g_sy_q, g_sy_d;
    logic [CNT_W-1:0]   snap_g_cnt_q, snap_g_cnt_d, snap_r_cnt_q, snap_r_cnt_d;
    logic [SUM_W-1:0]   snap_g_sx_q, snap_g_sx_d, snap_g_sy_q, snap_g_sy_d;
    state_e             state_q, state_d;
    logic [COORD_W-1:0] qx_q, qx_d, qy_q, qy_d;
    logic               found_frame_q, found_frame_d;
    logic               start_y_q, start_y_d;
    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
    logic               found_q, found_d, click_q, click_d;
    logic               valid_q, valid_d, overrun_q, overrun_d;

    logic               frame_end;
    logic               snap_take;
    logic               g_hit, r_hit;
    logic [CNT_W-1:0]   g_cnt_base, r_cnt_base;
    logic [SUM_W-1:0]   g_sx_base, g_sy_base;

    logic               div_start;
    logic [SUM_W-1:0]   div_dividend;
    logic [SUM_W-1:0]   div_quo;
    logic               div_busy, div_done;
    logic               div_unused;

    assign frame_end = !iVS && vs_q;
    assign snap_take = frame_end && (state_q == ST_IDLE);
    assign g_hit     = iVALID && iGREEN_HIT;
    assign r_hit     = iVALID && iRED_HIT;

    // clear first so a hit in the edge cycle lands in the new frame
    always_comb begin
        g_cnt_base = frame_end ? '0 : g_cnt_q;
        g_sx_base  = frame_end ? '0 : g_sx_q;
        g_sy_base  = frame_end ? '0 : g_sy_q;
        r_cnt_base = frame_end ? '0 : r_cnt_q;
        g_cnt_d    = g_hit ? sat_inc(g_cnt_base) : g_cnt_base;
        g_sx_d     = g_hit ? sat_add(g_sx_base, iX) : g_sx_base;
        g_sy_d     = g_hit ? sat_add(g_sy_base, iY) : g_sy_base;
        r_cnt_d    = r_hit ? sat_inc(r_cnt_base) : r_cnt_base;
    end

    always_comb begin
        snap_g_cnt_d = snap_take ? g_cnt_q : snap_g_cnt_q;
        snap_g_sx_d  = snap_take ? g_sx_q  : snap_g_sx_q;
        snap_g_sy_d  = snap_take ? g_sy_q  : snap_g_sy_q;
        snap_r_cnt_d = snap_take ? r_cnt_q : snap_r_cnt_q;
        overrun_d    = frame_end && (state_q != ST_IDLE);
    end

    always_comb begin
        state_d       = state_q;
        qx_d          = qx_q;
        qy_d          = qy_q;
        found_frame_d = found_frame_q;
        start_y_d     = 1'b0;
        div_start     = 1'b0;
        div_dividend  = snap_g_sx_q;
        x_d           = x_q;
        y_d           = y_q;
        found_d       = found_q;
        click_d       = click_q;
        valid_d       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (snap_take) state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (snap_g_cnt_q < MIN_PIX_C) begin
                    found_frame_d = 1'b0;
                    state_d       = ST_UPDATE;
                end else begin
                    found_frame_d = 1'b1;
                    div_start     = 1'b1;
                    state_d       = ST_DIV_X;
                end
            end
            ST_DIV_X: begin
                if (div_done) begin
                    qx_d      = div_quo[COORD_W-1:0];
                    start_y_d = 1'b1;
                    state_d   = ST_DIV_Y;
                end
            end
            ST_DIV_Y: begin
                // Y launches the cycle after X completes, while the divider is idle
                div_start    = start_y_q;
                div_dividend = snap_g_sy_q;
                if (div_done) begin
                    qy_d    = div_quo[COORD_W-1:0];
                    state_d = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                if (found_frame_q) begin
                    x_d     = qx_q;
                    y_d     = qy_q;
                    found_d = 1'b1;
                end else begin
                    found_d = 1'b0;
                end
                if (snap_r_cnt_q >= CLICK_ON_C)     click_d = 1'b1;
                else if (snap_r_cnt_q < CLICK_OFF_C) click_d = 1'b0;
                valid_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    seq_divider u_div (
        .iCLK     (iCLK),
        .iRST_N   (iRST_N),
        .start    (div_start),
        .dividend (div_dividend),
        .divisor  (snap_g_cnt_q),
        .quotient (div_quo),
        .busy     (div_busy),
        .done     (div_done)
    );

    // centroid is bounded by the largest coordinate, upper quotient bits are always zero
    assign div_unused = div_busy ^ (^div_quo[SUM_W-1:COORD_W]);

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            vs_q          <= 1'b0;
            g_cnt_q       <= '0;
            g_sx_q        <= '0;
            g_sy_q        <= '0;
            r_cnt_q       <= '0;
            snap_g_cnt_q  <= '0;
            snap_g_sx_q   <= '0;
            snap_g_sy_q   <= '0;
            snap_r_cnt_q  <= '0;
            state_q       <= ST_IDLE;
            qx_q          <= '0;
            qy_q          <= '0;
            found_frame_q <= 1'b0;
            start_y_q     <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            found_q       <= 1'b0;
            click_q       <= 1'b0;
            valid_q       <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            vs_q          <= iVS;
            g_cnt_q       <= g_cnt_d;
            g_sx_q        <= g_sx_d;
            g_sy_q        <= g_sy_d;
            r_cnt_q       <= r_cnt_d;
            snap_g_cnt_q  <= snap_g_cnt_d;
            snap_g_sx_q   <= snap_g_sx_d;
            snap_g_sy_q   <= snap_g_sy_d;
            snap_r_cnt_q  <= snap_r_cnt_d;
            state_q       <= state_d;
            qx_q          <= qx_d;
            qy_q          <= qy_d;
            found_frame_q <= found_frame_d;
            start_y_q     <= start_y_d;
            x_q           <= x_d;
            y_q           <= y_d;
            found_q       <= found_d;
            click_q       <= click_d;
            valid_q       <= valid_d;
            overrun_q     <= overrun_d;
        end
    end

    assign oX       = x_q;
    assign oY       = y_q;
    assign oFOUND   = found_q;
    assign oCLICK   = click_q;
    assign oVALID   = valid_q;
    assign oOVERRUN = overrun_q;

endmodule
